count_sequence_checker: RTL and testbench
=========================================

// Module: count_sequence_checker
// PURPOSE
//  Downstream monitor for the mod-(MAX_VAL+1) state-machine counter (0..10 wrap).
//  Samples the counter's 4-bit output every clock and checks for a legal +1 / wrap step.
//  Acquires lock after LOCK_LEN consecutive legal steps, then counts completed wraps.
//  Flags and counts every illegal step while locked.
//  Feeds status and diagnostics to the debug/test harness.
// PARAMETERS
//  WIDTH       4   width of sampled count value
//  MAX_VAL     10  terminal count; legal sequence 0..MAX_VAL, then 0
//  LOCK_LEN    3   consecutive legal steps needed to lock (>=1)
//  WRAP_CNT_W  8   width of wrap counter (wraps modulo 2^WRAP_CNT_W)
//  ERR_CNT_W   4   width of error counter (saturates at all-ones)
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           synchronous, active-high reset
//  x_in        in   WIDTH       counter value under test
//  locked      out  1           1 while FSM in LOCKED
//  wrap_pulse  out  1           1-cycle pulse per legal MAX_VAL->0 step while locked
//  wrap_count  out  WRAP_CNT_W  number of wrap_pulses since reset
//  err_pulse   out  1           1-cycle pulse per illegal step seen while locked
//  err_count   out  ERR_CNT_W   number of err_pulses since reset, saturating
//  last_val    out  WIDTH       previous sampled x_in
// BEHAVIOUR
//  Reset:
//   - One clock: one clock domain; reset is synchronous and active-high.
//   - While reset=1 at a rising edge, all outputs and internal state go to 0.
//   - FSM enters NO_REF; have_prev=0, run=0.
//   - Reset dominates all other events, including mid-run and while locked.
//  Legal step:
//   - exp = (prev==MAX_VAL) ? 0 : prev+1.
//   - A step is legal iff x_in == exp AND x_in <= MAX_VAL.
//   - x_in > MAX_VAL or X/Z on x_in is always illegal.
//  Timing:
//   - All outputs are registered and update at the edge that samples x_in.
//   - Latency is 1 clock from x_in valid to the status outputs.
//  FSM states:
//   - NO_REF: no valid prev. Next edge stores prev=x_in and goes to ACQUIRE with run=0.
//     If x_in > MAX_VAL, stay in NO_REF and do not store prev.
//   - ACQUIRE, legal step: run++. When run reaches LOCK_LEN -> LOCKED, run cleared.
//   - ACQUIRE, illegal step: run=0, stay in ACQUIRE. No err_pulse (not yet locked).
//   - LOCKED, legal step: stay. If prev==MAX_VAL && x_in==0: wrap_pulse=1, wrap_count++.
//   - LOCKED, illegal step: err_pulse=1, err_count++ (sat), -> ACQUIRE with run=0.
//  prev / last_val:
//   - prev updates to x_in every non-reset edge once out of NO_REF.
//   - prev updates even on illegal steps (re-sync from the new value).
//   - last_val mirrors prev.
//  Boundary rules:
//   - wrap_count rolls over 2^WRAP_CNT_W-1 -> 0 silently.
//   - err_count holds at all-ones.
//   - The lock-completing step can be MAX_VAL->0. That step gives no wrap_pulse;
//     only steps that start in LOCKED count.
//   - A stuck value (x_in==prev) is illegal.
//  Counter widths: counters are plain unsigned adds; run is width $clog2(LOCK_LEN+1).
// STRUCTURE
//  Package count_pkg holds:
//   - CNT_WIDTH=4 and CNT_MAX=10 (shared with the counter);
//   - typedef enum logic [1:0] {NO_REF, ACQUIRE, LOCKED} chk_state_t;
//   - function next_expected(prev) implementing the wrap rule.
//  One sub-module: sat_counter #(W) with inc/clr -> q, saturating; used for err_count.
//  Everything else stays inline in one always_ff plus one always_comb next-state block.
// TESTING
//  1. reset=1 for 2 clocks, then x_in=0,1,2,3
//     -> locked=1 at the edge sampling 3; all counts 0 before that.
//  2. Locked, free-running 0..10,0
//     -> wrap_pulse high exactly on the 10->0 sample; wrap_count=1; 2 laps -> 2.
//  3. Locked at 5, inject x_in=7
//     -> err_pulse 1 cycle, err_count=1, locked=0.
//     Then 8,9,10 -> locked=1 again; 10->0 then gives wrap_pulse.
//  4. x_in=12 right after reset -> stays NO_REF, last_val=0.
//     Then 4,5,6,7 -> locked; x_in=11 while locked -> err_pulse.
//  5. 20 injected errors, each followed by relock -> err_count stops at 15.
//     Run 256 legal wraps -> wrap_count returns to 0.
//  6. reset pulse while locked with wrap_count=3 -> next edge all outputs 0, locked=0.
//     Relock needs LOCK_LEN=3 new legal steps.

Source files
------------

// File: rtl/count_pkg.sv
// Shared definitions for the mod-(CNT_MAX+1) counter and its downstream sequence checker.
package count_pkg;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = 10;

  typedef enum logic [1:0] {NO_REF, ACQUIRE, LOCKED} chk_state_t;

  function automatic logic [CNT_WIDTH-1:0] next_expected(input logic [CNT_WIDTH-1:0] prev);
    return (prev == CNT_WIDTH'(CNT_MAX)) ? '0 : prev + 1'b1;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clock) begin
    if (clr)                  q <= '0;
    else if (inc && q != '1) q <= q + 1'b1;
  end
endmodule

// File: rtl/count_sequence_checker.sv
// Monitors a wrapping counter: locks after LOCK_LEN legal steps, then counts wraps and errors.
module count_sequence_checker
  import count_pkg::*;
#(
  parameter int WIDTH      = CNT_WIDTH,
  parameter int MAX_VAL    = CNT_MAX,
  parameter int LOCK_LEN   = 3,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_CNT_W  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      x_in,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  err_pulse,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WIDTH-1:0]      last_val
);
  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  chk_state_t            state, state_n;
  logic [WIDTH-1:0]      prev, prev_n, exp_val;
  logic [RUN_W-1:0]      run, run_n, run_inc;
  logic [WRAP_CNT_W-1:0] wrap_count_n;
  logic                  in_range, legal, wrap_n, err_n;

  // The package helper is tied to the shared counter geometry; other geometries use the same rule inline.
  generate
    if ((WIDTH == CNT_WIDTH) && (MAX_VAL == CNT_MAX)) begin : g_pkg_exp
      assign exp_val = next_expected(prev);
    end else begin : g_gen_exp
      assign exp_val = (prev == WIDTH'(MAX_VAL)) ? '0 : prev + 1'b1;
    end
  endgenerate

  // X/Z on x_in makes both terms unknown, which falls into the illegal branches below.
  assign in_range = (x_in <= WIDTH'(MAX_VAL));
  assign legal    = in_range && (x_in == exp_val);
  assign run_inc  = run + 1'b1;

  always_comb begin
    state_n      = state;
    prev_n       = prev;
    run_n        = run;
    wrap_n       = 1'b0;
    err_n        = 1'b0;
    wrap_count_n = wrap_count;
    case (state)
      NO_REF: begin
        if (in_range) begin
          prev_n  = x_in;
          run_n   = '0;
          state_n = ACQUIRE;
        end
      end
      ACQUIRE: begin
        prev_n = x_in;
        if (legal) begin
          if (run_inc == RUN_W'(LOCK_LEN)) begin
            state_n = LOCKED;
            run_n   = '0;
          end else begin
            run_n = run_inc;
          end
        end else begin
          run_n = '0;
        end
      end
      LOCKED: begin
        prev_n = x_in;
        if (legal) begin
          if (prev == WIDTH'(MAX_VAL)) begin
            wrap_n       = 1'b1;
            wrap_count_n = wrap_count + 1'b1;
          end
        end else begin
          err_n   = 1'b1;
          state_n = ACQUIRE;
          run_n   = '0;
        end
      end
      default: state_n = NO_REF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= NO_REF;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_count <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      run        <= run_n;
      locked     <= (state_n == LOCKED);
      wrap_pulse <= wrap_n;
      err_pulse  <= err_n;
      wrap_count <= wrap_count_n;
    end
  end

  assign last_val = prev;

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clock (clock),
    .clr   (reset),
    .inc   (err_n),
    .q     (err_count)
  );
endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker: reference model feeds a scoreboard, plus fixed checkpoints.
module tb_count_sequence_checker;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] x_in;
  logic       locked, wrap_pulse, err_pulse;
  logic [7:0] wrap_count;
  logic [3:0] err_count, last_val;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       locked;
    logic       wp;
    logic [7:0] wc;
    logic       ep;
    logic [3:0] ec;
    logic [3:0] lv;
  } exp_t;
  exp_t sbq[$];

  // reference model state: 0 = no reference, 1 = acquiring, 2 = locked
  int m_state = 0, m_run = 0, m_prev = 0, m_wc = 0, m_ec = 0;

  count_sequence_checker dut (
    .clock      (clock),
    .reset      (reset),
    .x_in       (x_in),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .last_val   (last_val)
  );

  always #5 clock = ~clock;

  function automatic int nxt(input int v);
    return (v == 10) ? 0 : v + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic r, input int x);
    exp_t e;
    exp_t got;
    int   ix;
    bit   lg;
    reset = r;
    x_in  = 4'(x);
    ix    = x;
    e.wp  = 1'b0;
    e.ep  = 1'b0;
    if (r) begin
      m_state = 0; m_run = 0; m_prev = 0; m_wc = 0; m_ec = 0;
    end else begin
      lg = (ix <= 10) && (ix == nxt(m_prev));
      if (m_state == 0) begin
        if (ix <= 10) begin m_prev = ix; m_run = 0; m_state = 1; end
      end else if (m_state == 1) begin
        if (lg) begin
          m_run++;
          if (m_run == 3) begin m_state = 2; m_run = 0; end
        end else m_run = 0;
        m_prev = ix;
      end else begin
        if (lg) begin
          if (m_prev == 10 && ix == 0) begin e.wp = 1'b1; m_wc = (m_wc + 1) % 256; end
        end else begin
          e.ep = 1'b1;
          if (m_ec < 15) m_ec++;
          m_state = 1; m_run = 0;
        end
        m_prev = ix;
      end
    end
    e.locked = (m_state == 2);
    e.wc     = 8'(m_wc);
    e.ec     = 4'(m_ec);
    e.lv     = 4'(m_prev);
    sbq.push_back(e);
    @(posedge clock);
    #1;
    got = sbq.pop_front();
    check("sb_locked",     32'(locked),     32'(got.locked));
    check("sb_wrap_pulse", 32'(wrap_pulse), 32'(got.wp));
    check("sb_wrap_count", 32'(wrap_count), 32'(got.wc));
    check("sb_err_pulse",  32'(err_pulse),  32'(got.ep));
    check("sb_err_count",  32'(err_count),  32'(got.ec));
    check("sb_last_val",   32'(last_val),   32'(got.lv));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_wp"},     32'(wrap_pulse), 32'd0);
    check({tag, "_wc"},     32'(wrap_count), 32'd0);
    check({tag, "_ep"},     32'(err_pulse), 32'd0);
    check({tag, "_ec"},     32'(err_count), 32'd0);
    check({tag, "_lv"},     32'(last_val), 32'd0);
  endtask

  initial begin
    int v;
    reset = 1'b1;
    x_in  = 4'd0;

    // 1: reset, then 0..3 locks on the sample of 3
    cyc(1, 0); cyc(1, 0);
    check_all_zero("rst");
    cyc(0, 0); cyc(0, 1); cyc(0, 2);
    check("t1_not_locked", 32'(locked), 32'd0);
    cyc(0, 3);
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_wc0", 32'(wrap_count), 32'd0);

    // 2: two laps, wrap pulse on the 10->0 sample only
    for (int i = 4; i <= 10; i++) cyc(0, i);
    cyc(0, 0);
    check("t2_wp", 32'(wrap_pulse), 32'd1);
    check("t2_wc1", 32'(wrap_count), 32'd1);
    for (int i = 1; i <= 10; i++) cyc(0, i);
    cyc(0, 0);
    check("t2_wc2", 32'(wrap_count), 32'd2);

    // 3: error at 5->7, relock on 8,9,10, then wrap
    for (int i = 1; i <= 5; i++) cyc(0, i);
    cyc(0, 7);
    check("t3_ep", 32'(err_pulse), 32'd1);
    check("t3_ec", 32'(err_count), 32'd1);
    check("t3_unlock", 32'(locked), 32'd0);
    cyc(0, 8);
    check("t3_ep_1cyc", 32'(err_pulse), 32'd0);
    cyc(0, 9); cyc(0, 10);
    check("t3_relock", 32'(locked), 32'd1);
    cyc(0, 0);
    check("t3_wp", 32'(wrap_pulse), 32'd1);
    check("t3_wc3", 32'(wrap_count), 32'd3);

    // 4: out-of-range first sample is ignored; out-of-range while locked is an error
    cyc(1, 0);
    cyc(0, 12);
    check("t4_noref_lv", 32'(last_val), 32'd0);
    check("t4_noref_lock", 32'(locked), 32'd0);
    cyc(0, 4); cyc(0, 5); cyc(0, 6); cyc(0, 7);
    check("t4_locked", 32'(locked), 32'd1);
    cyc(0, 11);
    check("t4_ep", 32'(err_pulse), 32'd1);
    check("t4_lv11", 32'(last_val), 32'd11);

    // 5: 20 error/relock rounds saturate err_count; stuck value is the error
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0); cyc(0, 1); cyc(0, 2); cyc(0, 3);
      cyc(0, 3);
    end
    check("t5_ec_sat", 32'(err_count), 32'd15);
    check("t5_unlock", 32'(locked), 32'd0);
    cyc(0, 4); cyc(0, 5); cyc(0, 6);
    check("t5_relock", 32'(locked), 32'd1);
    v = 6;
    for (int k = 0; k < 256 * 11; k++) begin
      v = nxt(v);
      cyc(0, v);
    end
    check("t5_wc_roll", 32'(wrap_count), 32'd0);
    check("t5_ec_hold", 32'(err_count), 32'd15);

    // 6: reset while locked with wrap_count=3, then relock needs 3 fresh steps
    for (int k = 0; k < 3 * 11; k++) begin
      v = nxt(v);
      cyc(0, v);
    end
    check("t6_wc3", 32'(wrap_count), 32'd3);
    cyc(1, nxt(v));
    check_all_zero("t6_rst");
    cyc(0, 7); cyc(0, 8); cyc(0, 9);
    check("t6_not_locked", 32'(locked), 32'd0);
    cyc(0, 10);
    check("t6_relock", 32'(locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
